// File: rtl/cdc_handshake_rx.sv
// Destination side of a 2-phase toggle req/ack CDC handshake: capture, valid/ready hand-off, ack toggle.
// Optional macro CDC_HS_RX_PARITY_EN adds async_par input and a par_err pulse output.
module cdc_handshake_rx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_dest,
  input  logic              rst,
  input  logic              req_sync,
  input  logic [DATA_W-1:0] async_data,
`ifdef CDC_HS_RX_PARITY_EN
  input  logic              async_par,
  output logic              par_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ack_toggle,
  output logic              overrun_err,
  output logic [CNT_W-1:0]  xfer_cnt
);

  typedef enum logic {IDLE = 1'b0, VALID = 1'b1} state_t;

  state_t            r_state;
  logic              r_req_prev;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_ack;
  logic              r_overrun;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_req_edge;
`ifdef CDC_HS_RX_PARITY_EN
  logic              r_par_err;
`endif

  // req_prev only advances when an edge is consumed, so an edge arriving
  // while a word is held stays pending until the word is accepted.
  assign w_req_edge = req_sync ^ r_req_prev;

  always_ff @(posedge clk_dest) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req_prev <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_ack      <= 1'b0;
      r_overrun  <= 1'b0;
      r_cnt      <= '0;
`ifdef CDC_HS_RX_PARITY_EN
      r_par_err  <= 1'b0;
`endif
    end else begin
`ifdef CDC_HS_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_req_edge) begin
            r_data     <= async_data;
            r_req_prev <= req_sync;
            r_valid    <= 1'b1;
            r_state    <= VALID;
`ifdef CDC_HS_RX_PARITY_EN
            r_par_err  <= ^{async_data, async_par};
`endif
          end
        end
        VALID: begin
          if (w_req_edge) r_overrun <= 1'b1;
          if (out_ready) begin
            r_valid <= 1'b0;
            r_ack   <= ~r_ack;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign ack_toggle  = r_ack;
  assign overrun_err = r_overrun;
  assign xfer_cnt    = r_cnt;
`ifdef CDC_HS_RX_PARITY_EN
  assign par_err     = r_par_err;
`endif

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Self-checking bench for cdc_handshake_rx: vector table, directed corner sequences, random vs transaction model.
module tb_cdc_handshake_rx;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int EW = 1 + DW + 1 + 1 + CW;

  logic          clk_dest = 1'b0;
  logic          rst = 1'b1;
  logic          req_sync = 1'b0;
  logic [DW-1:0] async_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          ack_toggle;
  logic          overrun_err;
  logic [CW-1:0] xfer_cnt;
`ifdef CDC_HS_RX_PARITY_EN
  logic          async_par = 1'b0;
  logic          par_err;
`endif

  int checks = 0;
  int errors = 0;

  cdc_handshake_rx #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_dest   (clk_dest),
    .rst        (rst),
    .req_sync   (req_sync),
    .async_data (async_data),
`ifdef CDC_HS_RX_PARITY_EN
    .async_par  (async_par),
    .par_err    (par_err),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .ack_toggle (ack_toggle),
    .overrun_err(overrun_err),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk_dest = ~clk_dest;

  // Transaction-level reference: is a word held, which request level was last taken,
  // plus the held word, ack level, sticky overrun and completed-transfer tally.
  logic          m_held;
  logic          m_taken_lvl;
  logic [DW-1:0] m_word;
  logic          m_ack;
  logic          m_ovr;
  int            m_done;

  function automatic logic [EW-1:0] mk(input logic v, input logic [DW-1:0] d,
                                       input logic a, input logic o, input int c);
    logic [CW-1:0] cc;
    cc = CW'(c % (1 << CW));
    return {v, d, a, o, cc};
  endfunction

  function automatic logic [EW-1:0] model_exp();
    return mk(m_held, m_word, m_ack, m_ovr, m_done);
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] exp);
    logic [EW-1:0] got;
    got = {out_valid, out_data, ack_toggle, overrun_err, xfer_cnt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got valid=%0b data=%h ack=%0b ovr=%0b cnt=%0d, expected valid=%0b data=%h ack=%0b ovr=%0b cnt=%0d",
               name, got[EW-1], got[EW-2 -: DW], got[CW+1], got[CW], got[CW-1:0],
               exp[EW-1], exp[EW-2 -: DW], exp[CW+1], exp[CW], exp[CW-1:0]);
    end
  endtask

  task automatic step(input logic r, input logic q, input logic [DW-1:0] d, input logic rd);
    rst = r; req_sync = q; async_data = d; out_ready = rd;
    @(posedge clk_dest);
    if (r) begin
      m_held = 0; m_taken_lvl = 0; m_word = '0; m_ack = 0; m_ovr = 0; m_done = 0;
    end else if (!m_held) begin
      if (q != m_taken_lvl) begin m_held = 1; m_word = d; m_taken_lvl = q; end
    end else begin
      if (q != m_taken_lvl) m_ovr = 1;
      if (rd) begin m_held = 0; m_ack = ~m_ack; m_done++; end
    end
    #1;
  endtask

  typedef struct {
    logic          r;
    logic          q;
    logic [DW-1:0] d;
    logic          rd;
    logic [EW-1:0] exp;
  } vec_t;

  vec_t tbl[14];
  logic lvl;

  initial begin
    tbl[0]  = '{1, 0, 8'h00, 0, mk(0, 8'h00, 0, 0, 0)};
    tbl[1]  = '{0, 0, 8'h00, 0, mk(0, 8'h00, 0, 0, 0)};
    tbl[2]  = '{0, 1, 8'hA5, 1, mk(1, 8'hA5, 0, 0, 0)};
    tbl[3]  = '{0, 1, 8'hA5, 1, mk(0, 8'hA5, 1, 0, 1)};
    tbl[4]  = '{0, 1, 8'h3C, 0, mk(0, 8'hA5, 1, 0, 1)};
    tbl[5]  = '{0, 0, 8'h3C, 0, mk(1, 8'h3C, 1, 0, 1)};
    tbl[6]  = '{0, 0, 8'h00, 0, mk(1, 8'h3C, 1, 0, 1)};
    tbl[7]  = '{0, 0, 8'hFF, 0, mk(1, 8'h3C, 1, 0, 1)};
    tbl[8]  = '{0, 1, 8'h77, 0, mk(1, 8'h3C, 1, 1, 1)};
    tbl[9]  = '{0, 1, 8'h77, 1, mk(0, 8'h3C, 0, 1, 2)};
    tbl[10] = '{0, 1, 8'h77, 0, mk(1, 8'h77, 0, 1, 2)};
    tbl[11] = '{0, 1, 8'h77, 1, mk(0, 8'h77, 1, 1, 3)};
    tbl[12] = '{1, 1, 8'h77, 1, mk(0, 8'h00, 0, 0, 0)};
    tbl[13] = '{0, 0, 8'h99, 1, mk(0, 8'h00, 0, 0, 0)};

    @(posedge clk_dest); #1;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].q, tbl[i].d, tbl[i].rd);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // reset then idle
    step(1, 0, 8'h00, 0);
    repeat (10) step(0, 0, 8'h00, 0);
    chk("idle10", mk(0, 8'h00, 0, 0, 0));

    // single word, consumer always ready
    step(0, 1, 8'hA5, 1); chk("a5_capture", mk(1, 8'hA5, 0, 0, 0));
    step(0, 1, 8'hA5, 1); chk("a5_ack", mk(0, 8'hA5, 1, 0, 1));

    // consumer stalls 4 cycles
    step(0, 0, 8'hA5, 0); chk("stall_cap", mk(1, 8'hA5, 1, 0, 1));
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'hA5, 0); chk($sformatf("stall_hold%0d", i), mk(1, 8'hA5, 1, 0, 1));
    end
    step(0, 0, 8'hA5, 1); chk("stall_ack", mk(0, 8'hA5, 0, 0, 2));

    // overrun: second toggle while holding, then delivered after accept
    step(0, 1, 8'h11, 0); chk("ovr_cap1", mk(1, 8'h11, 0, 0, 2));
    step(0, 0, 8'h22, 0); chk("ovr_flag", mk(1, 8'h11, 0, 1, 2));
    step(0, 0, 8'h22, 1); chk("ovr_acc1", mk(0, 8'h11, 1, 1, 3));
    step(0, 0, 8'h22, 0); chk("ovr_cap2", mk(1, 8'h22, 1, 1, 3));
    step(0, 0, 8'h22, 1); chk("ovr_acc2", mk(0, 8'h22, 0, 1, 4));
    step(0, 0, 8'h22, 1); chk("ovr_sticky", mk(0, 8'h22, 0, 1, 4));

    // 17 back-to-back words, counter wraps
    step(1, 0, 8'h00, 0);
    lvl = 1'b0;
    for (int k = 0; k < 17; k++) begin
      lvl = ~lvl;
      step(0, lvl, 8'(k), 1);
      chk($sformatf("b2b_cap%0d", k), mk(1, 8'(k), k[0], 0, k));
      step(0, lvl, 8'(k), 1);
    end
    chk("b2b_end", mk(0, 8'h10, 1, 0, 1));

`ifdef CDC_HS_RX_PARITY_EN
    step(1, 0, 8'h00, 0);
    async_par = 1'b1;
    step(0, 1, 8'h03, 0);
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_bad: got %0b expected 1", par_err); end
    step(0, 1, 8'h03, 1);
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_pulse: got %0b expected 0", par_err); end
    async_par = 1'b0;
    step(0, 0, 8'h03, 0);
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_good: got %0b expected 0", par_err); end
    step(0, 0, 8'h03, 1);
`endif

    // random traffic against the model
    step(1, 0, 8'h00, 0);
    lvl = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      logic r;
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) lvl = ~lvl;
      if (r) lvl = 1'b0;
      step(r, lvl, 8'($urandom), 1'($urandom));
      chk("rand", model_exp());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdc_handshake_rx.md
Name: cdc_handshake_rx

Overview:
- Destination-side receiver of a 2-phase (toggle) request/acknowledge CDC handshake.
- Sits directly downstream of the 2-FF synchronizer: consumes its synchronized request toggle (sync_signal → req_sync) in the clk_dest domain.
- Captures a multi-bit bus held stable by the source, presents it on a valid/ready interface and returns an acknowledge toggle. The ack toggle is re-synchronized into the source domain by a second synchronizer instance.

Parameters:
- DATA_W, 8, width of the transferred data word.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk_dest  in  1  destination clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_sync  in  1  request toggle, already 2-FF synchronized; each level change = one new word.
- async_data  in  DATA_W  source data; source guarantees it is stable from its req toggle until it sees the matching ack toggle.
- out_valid  out  1  captured word available.
- out_ready  in  1  consumer accepts the word when high with out_valid.
- out_data  out  DATA_W  captured word.
- ack_toggle  out  1  acknowledge toggle back to the source domain.
- overrun_err  out  1  sticky protocol-violation flag.
- xfer_cnt  out  CNT_W  count of completed transfers.

Behaviour:
- Reset (rst high at a clk_dest edge), next-cycle values:
  - out_valid=0, out_data=0, ack_toggle=0, overrun_err=0, xfer_cnt=0.
  - req_prev=0, state=IDLE.
  - Source and destination toggles both start at 0.
- Edge detect: req_edge = req_sync ^ req_prev. req_prev updates only when an edge is consumed.
- State IDLE:
  - out_valid=0.
  - On req_edge: out_data<=async_data, req_prev<=req_sync, go to VALID.
  - out_valid is 1 in the cycle after req_sync first shows the new level (1-cycle capture latency).
- State VALID:
  - out_valid=1; out_data held constant.
  - On out_valid&&out_ready: ack_toggle flips, xfer_cnt increments (wraps 2^CNT_W-1→0), go to IDLE.
  - out_valid is 0 the next cycle.
- Back-to-back: a new req_edge already present in the first IDLE cycle after accept is captured in that cycle. Minimum 2 cycles per word.
- Overrun (req_edge seen while in VALID):
  - overrun_err<=1, sticky until rst.
  - The edge is still not consumed: req_prev is unchanged, so it is captured after the current word is accepted.
  - The current out_data is never overwritten.
- out_ready while out_valid=0 is ignored.
- rst mid-transfer:
  - Aborts to IDLE; held word is discarded; ack_toggle returns to 0.
  - The source domain must be reset in the same window; otherwise behaviour is undefined.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: CDC_HS_RX_PARITY_EN.
- When defined:
  - Extra input async_par (1) carries the source's even parity over async_data. It is captured with the data.
  - Extra output par_err (1) is a registered 1-cycle pulse, asserted in the cycle out_valid first rises, if ^{async_data,async_par} != 0.
  - The word is still delivered and acked normally.
- When undefined: async_par and par_err do not exist, and there is no parity logic.

Test Plan:
- Reset then idle 10 cycles → out_valid=0, ack_toggle=0, xfer_cnt=0, overrun_err=0.
- async_data=8'hA5, req_sync 0→1 at cycle 5, out_ready=1 → out_valid=1, out_data=8'hA5 at cycle 6; ack_toggle=1 and out_valid=0 at cycle 7; xfer_cnt=1.
- Same transfer with out_ready low for 4 cycles → out_valid and out_data=8'hA5 held 4 cycles; ack flips only on the cycle after out_ready rises.
- req_sync toggles again while in VALID (out_ready=0) → overrun_err=1 and stays 1. After accept, the second word is presented; xfer_cnt reaches 2.
- CNT_W=4, 17 back-to-back transfers → xfer_cnt=1; ack_toggle=1.
- With CDC_HS_RX_PARITY_EN: data 8'h03 with async_par=1 → par_err pulses 1 cycle alongside out_valid; with async_par=0 → par_err stays 0.
